pc_fetch: RTL
=============

# pc_fetch

Program-counter and instruction-fetch sequencer for the processor datapath. It holds the 8-bit PC and drives the operands of the external 8-bit PC adder. It consumes the adder's sum as the next PC. It fetches each instruction from instruction memory through a request/acknowledge handshake and presents it to decode through a valid/ready handshake.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `HALT_OPCODE`, default 5'b00000: opcode in `instr[15:11]` that halts fetch.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `add_a`  out  8: adder operand A; always equals `pc`.
- `add_b`  out  8: adder operand B.
- `add_result`  in  8: adder sum, combinational from `add_a` + `add_b`, modulo 256.
- `imem_addr`  out  8: instruction address; always equals `pc`.
- `imem_req`  out  1: fetch request.
- `imem_ack`  in  1: memory has `imem_data` valid this cycle.
- `imem_data`  in  16: instruction word.
- `instr`  out  16: latched instruction for decode.
- `instr_valid`  out  1: `instr` is valid.
- `instr_ready`  in  1: decode accepts `instr` this cycle.
- `branch_en`  in  1: the accepted instruction redirects the PC.
- `branch_offset`  in  8: two's-complement PC offset, used when `branch_en` = 1.
- `halted`  out  1: fetch stopped on `HALT_OPCODE`.

## Operation
- **States:** IDLE, FETCH, ISSUE, HALT.
- **Reset** (sampled on a `clk` edge while `reset` = 1) overrides everything, including mid-fetch and mid-issue:
  - `pc` = `RESET_PC`, state = IDLE.
  - `imem_req` = 0, `instr_valid` = 0, `instr` = 16'h0000, `halted` = 0.
- **IDLE:** all handshake outputs low; moves unconditionally to FETCH on the next edge.
- **FETCH:**
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - On `imem_ack` = 1: latch `instr` <= `imem_data` and go to ISSUE.
  - Otherwise stay in FETCH with the request held.
- **ISSUE:**
  - `instr_valid` = 1 and `imem_req` = 0.
  - `instr` is held stable until `instr_ready` = 1.
- **On the accept edge** (ISSUE with `instr_ready` = 1):
  - If `instr[15:11]` == `HALT_OPCODE`: go to HALT; `pc` is unchanged; `branch_en` is ignored.
  - Else: `pc` <= `add_result` and go to FETCH.
- **HALT:**
  - `halted` = 1, `instr_valid` = 0, `imem_req` = 0.
  - `pc` is frozen; only `reset` exits this state.
- **Adder operand B:**
  - `add_b` = `branch_offset` when in ISSUE with `branch_en` = 1.
  - `add_b` = 8'h01 in every other case.
  - `add_b` is driven combinationally from the state and `branch_en`.
- **Arithmetic:** all PC arithmetic is 8-bit modulo 256 with no carry out. Therefore 8'hFF + 1 wraps to 8'h00, and a negative offset below 0 wraps to the top of the address space.
- **Ignored inputs:**
  - `imem_ack` outside FETCH.
  - `instr_ready` outside ISSUE.
  - `branch_en` unless in ISSUE with `instr_ready` = 1 on the same cycle.
- `branch_en` is qualified only at the accept edge. Decode may change `branch_en` freely while `instr_ready` = 0.

## Timing
- **After reset release:**
  - Cycle 0: IDLE.
  - Cycle 1: FETCH, `imem_req` = 1.
  - The ack edge is the earliest point to latch; `instr_valid` rises in the cycle after the ack.
- **Zero-wait memory** (`imem_ack` high in the first FETCH cycle) **with `instr_ready` always high:**
  - One instruction every 2 cycles.
  - The PC advances on every second edge.
- **Wait states:** each cycle of memory wait state or decode back-pressure adds exactly one cycle.
- **Branch latency:** the redirected `imem_addr` appears in the cycle immediately after the accept edge. No wrong-path fetch is ever issued.
- **Output timing:** all outputs except `add_b` are registered state or direct functions of state/`pc`. `add_b` depends combinationally on `branch_en`.

## Test plan
- **Reset and sequential fetch.** Stimulus: reset with `RESET_PC` = 8'h00; memory acks on the first FETCH cycle; `instr_ready` = 1; opcodes non-halt. Response: `imem_addr` steps 00, 01, 02, 03 on every second cycle, and `instr_valid` pulses one cycle each.
- **Wrap-around.** Stimulus: `RESET_PC` = 8'hFE with three sequential fetches. Response: addresses FE, FF, 00.
- **Branch.** Stimulus: at `pc` = 8'h10, accept with `branch_en` = 1 and `branch_offset` = 8'hFC. Response: next `imem_addr` = 8'h0C, `add_b` = 8'hFC during that cycle, then sequential fetch resumes from 8'h0C.
- **Back-pressure and wait states.** Stimulus: memory delays ack by 3 cycles; decode holds `instr_ready` = 0 for 4 cycles. Response: `imem_req` stays high for 4 cycles, `instr` stays constant while `instr_valid` = 1, and `pc` does not change until the accept edge.
- **Halt.** Stimulus: fetch word 16'h0000 at `pc` = 8'h05 with `branch_en` = 1 at accept. Response: `halted` = 1 from the next cycle, `pc` stays 8'h05, no further `imem_req`, and `imem_ack` pulses are ignored.
- **Reset mid-operation.** Stimulus: assert `reset` during FETCH and also during ISSUE with `instr_valid` = 1. Response: on the next edge all outputs return to their reset values and `pc` = `RESET_PC`. After release, fetch restarts with IDLE, then FETCH.

Source files
------------

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer.
// Drives the external PC adder and fetches words for decode.
module pc_fetch #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [4:0] HALT_OPCODE = 5'b00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  input  logic [7:0]  add_result,
  output logic [7:0]  imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [7:0]  branch_offset,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  logic in_issue;
  logic accept;
  logic is_halt;

  assign in_issue = (state_q == ISSUE);
  assign accept   = in_issue && instr_ready;
  assign is_halt  = (instr_q[15:11] == HALT_OPCODE);

  // Offset only reaches the adder while decode can redirect us
  assign add_a = pc_q;
  assign add_b = (in_issue && branch_en) ? branch_offset : 8'h01;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (is_halt) begin
            state_d = HALT;
          end else begin
            pc_d    = add_result;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH);
  assign instr       = instr_q;
  assign instr_valid = in_issue;
  assign halted      = (state_q == HALT);

endmodule
